// File: rtl/pulse_burst_decoder.sv
// Pulse-train receiver: synchronises a pulse line, rejects short glitches,
// measures accepted pulse widths and reports per-burst pulse counts.
module pulse_burst_decoder #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned MIN_WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             burst_valid,
  output logic [CNT_W-1:0] burst_count,
  output logic [CNT_W-1:0] last_width,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(MIN_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             burst_valid_q, burst_valid_d;
  logic [CNT_W-1:0] burst_count_q, burst_count_d;
  logic [CNT_W-1:0] last_width_q, last_width_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             pulse_s;

  assign pulse_s = sync2_q;

  always_comb begin
    sync1_d       = pulse_in;
    sync2_d       = sync1_q;
    state_d       = state_q;
    width_cnt_d   = width_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    acc_cnt_d     = acc_cnt_q;
    acc_ovf_d     = acc_ovf_q;
    burst_valid_d = 1'b0;
    burst_count_d = burst_count_q;
    last_width_d  = last_width_q;
    overflow_d    = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (pulse_s) begin
          state_d     = S_HIGH;
          width_cnt_d = CNT_ONE;
        end
      end
      S_HIGH: begin
        if (pulse_s) begin
          if (width_cnt_q != CNT_MAX) width_cnt_d = width_cnt_q + 1'b1;
        end else if (width_cnt_q >= MIN_W) begin
          last_width_d = width_cnt_q;
          if (acc_cnt_q == CNT_MAX) acc_ovf_d = 1'b1;
          else                      acc_cnt_d = acc_cnt_q + 1'b1;
          state_d   = S_GAP;
          gap_cnt_d = CNT_ONE;
        end else if (acc_cnt_q != '0) begin
          // Rejected glitch inside an open burst: the gap restarts from here.
          state_d   = S_GAP;
          gap_cnt_d = CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (pulse_s) begin
          state_d     = S_HIGH;
          width_cnt_d = CNT_ONE;
        end else if (gap_cnt_q == IDLE_LAST) begin
          burst_count_d = acc_cnt_q;
          overflow_d    = acc_ovf_q;
          burst_valid_d = 1'b1;
          acc_cnt_d     = '0;
          acc_ovf_d     = 1'b0;
          state_d       = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      width_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      acc_cnt_q     <= '0;
      acc_ovf_q     <= 1'b0;
      burst_valid_q <= 1'b0;
      burst_count_q <= '0;
      last_width_q  <= '0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      width_cnt_q   <= width_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_ovf_q     <= acc_ovf_d;
      burst_valid_q <= burst_valid_d;
      burst_count_q <= burst_count_d;
      last_width_q  <= last_width_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
    end
  end

  assign burst_valid = burst_valid_q;
  assign burst_count = burst_count_q;
  assign last_width  = last_width_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_burst_decoder.sv
// Directed and random stimulus for pulse_burst_decoder, checked every cycle
// against a run-length reference model plus directed burst-level expectations.
module tb_pulse_burst_decoder;

  localparam int CNT_W = 8;
  localparam int IDLE  = 16;
  localparam int MINW  = 2;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pulse_in = 1'b0;
  logic             burst_valid;
  logic [CNT_W-1:0] burst_count;
  logic [CNT_W-1:0] last_width;
  logic             overflow;
  logic             busy;

  pulse_burst_decoder #(.CNT_W(CNT_W), .IDLE_CYCLES(IDLE), .MIN_WIDTH(MINW)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .burst_valid(burst_valid),
    .burst_count(burst_count), .last_width(last_width), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Burst-level bookkeeping for the directed checks
  int   cyc = 0, strobes = 0, bc_sum = 0, busy_cycles = 0;
  int   fall_cyc = 0, strobe_cyc = 0;
  int   st_bc = 0, st_ovf = 0;
  logic prev_in = 1'b0;

  // Reference model: pulse_s is pulse_in two samples late; a burst is closed by
  // IDLE consecutive low samples after the last high run while pulses are pending.
  logic            m_s1 = 0, m_s2 = 0;
  int              m_hi = 0, m_lo = 0, m_acc = 0;
  logic            m_ovf = 0, m_valid = 0, m_ovf_out = 0;
  logic [CNT_W-1:0] m_bc = '0, m_lw = '0;

  task automatic model_step(input logic r, input logic v);
    logic s;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_hi = 0; m_lo = 0; m_acc = 0;
      m_ovf = 0; m_valid = 0; m_ovf_out = 0; m_bc = '0; m_lw = '0;
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = v;
      m_valid = 0;
      if (s) begin
        if (m_hi < MAXV) m_hi++;
        m_lo = 0;
      end else begin
        if (m_hi > 0) begin
          if (m_hi >= MINW) begin
            m_lw = CNT_W'(m_hi);
            if (m_acc == MAXV) m_ovf = 1; else m_acc++;
          end
          m_hi = 0;
          m_lo = 1;
        end else if (m_lo < IDLE) begin
          m_lo++;
        end
        if (m_lo == IDLE && m_acc > 0) begin
          m_valid = 1; m_bc = CNT_W'(m_acc); m_ovf_out = m_ovf;
          m_acc = 0; m_ovf = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({burst_valid, burst_count, last_width, overflow, busy});
  endfunction

  task automatic step(input logic v, input logic r);
    logic m_busy;
    @(negedge clk);
    pulse_in = v;
    rst      = r;
    if (prev_in && !v) fall_cyc = cyc;
    prev_in = v;
    @(posedge clk);
    model_step(r, v);
    #1;
    m_busy = (m_hi > 0) || (m_acc > 0);
    check("outputs", out_vec(), 32'({m_valid, m_bc, m_lw, m_ovf_out, m_busy}));
    if (burst_valid === 1'b1) begin
      strobes++;
      bc_sum += int'(burst_count);
      st_bc  = int'(burst_count);
      st_ovf = int'(overflow);
      strobe_cyc = cyc;
    end
    if (busy === 1'b1) busy_cycles++;
    cyc++;
  endtask

  task automatic pulse(input int w, input int g);
    for (int i = 0; i < w; i++) step(1'b1, 1'b0);
    for (int i = 0; i < g; i++) step(1'b0, 1'b0);
  endtask

  task automatic clear_stats();
    strobes = 0; bc_sum = 0; busy_cycles = 0;
  endtask

  initial begin
    // Reset with the line toggling
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("reset_outputs", out_vec(), 32'd0);
    step(1'b0, 1'b0);
    check("reset_after", out_vec(), 32'd0);
    pulse(0, 24);

    // Single pulse; latency counted from the first low pulse_in cycle
    clear_stats();
    pulse(5, 20);
    check("single_strobes", strobes, 1);
    check("single_count", st_bc, 1);
    check("single_width", last_width, 5);
    check("single_ovf", st_ovf, 0);
    check("single_latency", strobe_cyc - fall_cyc + 1, IDLE + 2);

    // Three-pulse burst
    clear_stats();
    pulse(3, 4); pulse(3, 4); pulse(3, 20);
    check("three_strobes", strobes, 1);
    check("three_count", st_bc, 3);
    check("three_width", last_width, 3);

    // Gap boundary: IDLE-1 lows keep the burst open, IDLE lows close it
    clear_stats();
    pulse(4, IDLE - 1); pulse(4, 20);
    check("gap15_strobes", strobes, 1);
    check("gap15_count", st_bc, 2);
    clear_stats();
    pulse(4, IDLE); pulse(4, 20);
    check("gap16_strobes", strobes, 2);
    check("gap16_count_sum", bc_sum, 2);

    // Glitch filtering
    clear_stats();
    pulse(1, 20);
    check("lone_glitch_strobes", strobes, 0);
    check("lone_glitch_busy", busy_cycles, 1);
    clear_stats();
    pulse(4, 3); pulse(1, 3); pulse(4, 20);
    check("glitch_mid_strobes", strobes, 1);
    check("glitch_mid_count", st_bc, 2);
    check("glitch_mid_width", last_width, 4);

    // Count saturation
    clear_stats();
    for (int i = 0; i < 300; i++) pulse(2, 2);
    pulse(0, 20);
    check("sat_strobes", strobes, 1);
    check("sat_count", st_bc, MAXV);
    check("sat_ovf", st_ovf, 1);

    // Width saturation
    clear_stats();
    pulse(300, 20);
    check("wsat_width", last_width, MAXV);
    check("wsat_count", st_bc, 1);
    check("wsat_ovf", st_ovf, 0);

    // Reset mid-burst discards it
    clear_stats();
    pulse(3, 3); pulse(3, 3);
    step(1'b0, 1'b1);
    check("midrst_outputs", out_vec(), 32'd0);
    pulse(0, 20);
    check("midrst_strobes", strobes, 0);

    // Random trains with occasional resets
    for (int i = 0; i < 150; i++) begin
      pulse($urandom_range(1, 6), $urandom_range(1, 20));
      if ($urandom_range(0, 39) == 0) step(1'b0, 1'b1);
    end
    pulse(0, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
